// File: rtl/temp_sensor_reader.sv
// =============================================================================
// temp_sensor_reader -- periodic SPI mode-0 reader for the board temperature
// sensor; emits the signed integer °C part of each good frame. Rev 1.0
// =============================================================================
`default_nettype none

module temp_sensor_reader #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       miso_i,
    output logic       sck_o,
    output logic       cs_no,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SCK_HIGH = 3'd2,
        S_SCK_LOW  = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         bit_q, bit_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [15:0]        shift_q, shift_d;
    logic               en_q;
    logic               armed_q, armed_d;
    logic               sck_q, sck_d;
    logic               cs_n_q, cs_n_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               start;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        err_d   = err_q;
        valid_d = 1'b0;

        // armed_q marks that en has been low, so the next high cycle in IDLE starts a frame
        start   = (state_q == S_IDLE) && en_q && (armed_q || (per_q == PER_LAST));

        if (!en_q) begin
            armed_d = 1'b1;
        end else if (start) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end

        if (start) begin
            per_d = '0;
        end else if (en_q) begin
            per_d = per_q + 1'b1;
        end else begin
            per_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_SCK_HIGH;
                    div_d   = '0;
                    shift_d = {shift_q[14:0], miso_i};
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SCK_HIGH: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_SCK_LOW;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SCK_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 5'd15) begin
                        state_d = S_DONE;
                        // Faulted frames keep the last good temperature on data_o
                        if (shift_q[0]) begin
                            err_d = 1'b1;
                        end else begin
                            data_d  = shift_q[15:8];
                            valid_d = 1'b1;
                            err_d   = 1'b0;
                        end
                    end else begin
                        state_d = S_SCK_HIGH;
                        shift_d = {shift_q[14:0], miso_i};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sck_d  = (state_d == S_SCK_HIGH);
        cs_n_d = !((state_d == S_SETUP) || (state_d == S_SCK_HIGH) || (state_d == S_SCK_LOW));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            per_q   <= '0;
            shift_q <= '0;
            en_q    <= 1'b0;
            armed_q <= 1'b1;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            per_q   <= per_d;
            shift_q <= shift_d;
            en_q    <= en_i;
            armed_q <= armed_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign sck_o   = sck_q;
    assign cs_no   = cs_n_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_temp_sensor_reader.sv
// =============================================================================
// tb_temp_sensor_reader -- directed self-checking bench with a mode-0 sensor
// model. Rev 1.0
// =============================================================================
`default_nettype none

module tb_temp_sensor_reader;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 100;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i   = 1'b0;
    logic       miso_i = 1'b0;
    logic       sck_o;
    logic       cs_no;
    logic [7:0] data_o;
    logic       valid_o;
    logic       err_o;

    temp_sensor_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (en_i),
        .miso_i  (miso_i),
        .sck_o   (sck_o),
        .cs_no   (cs_no),
        .data_o  (data_o),
        .valid_o (valid_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc++;

    // Sensor: first bit on cs fall, next bit after every sck fall
    logic [15:0] sensor_word = 16'h0000;
    logic [15:0] sh          = 16'h0000;
    logic        cs_last     = 1'b1;
    logic        sck_last    = 1'b0;
    always @(cs_no or sck_o) begin
        if (!cs_no && cs_last) begin
            sh = sensor_word;
        end else if (!cs_no && !sck_o && sck_last) begin
            sh = {sh[14:0], 1'b0};
        end
        cs_last  = cs_no;
        sck_last = sck_o;
        miso_i   = sh[15];
    end

    int   fall_q[$];
    int   valid_q[$];
    int   sck_rises  = 0;
    int   cs_low_cnt = 0;
    logic prev_cs    = 1'b1;
    logic prev_sck   = 1'b0;
    always @(negedge clk_i) begin
        if (prev_cs && !cs_no) fall_q.push_back(cyc);
        if (!prev_sck && sck_o) sck_rises++;
        if (!cs_no) cs_low_cnt++;
        if (valid_o) valid_q.push_back(cyc);
        prev_cs  = cs_no;
        prev_sck = sck_o;
    end

    int fb, vb, rb, cb, t_en;

    task automatic mark_bases();
        fb = fall_q.size();
        vb = valid_q.size();
        rb = sck_rises;
        cb = cs_low_cnt;
    endtask

    task automatic run_frame(input logic [15:0] w, input int hold, input int tail);
        sensor_word = w;
        mark_bases();
        @(negedge clk_i);
        en_i = 1'b1;
        t_en = cyc + 1;
        repeat (hold) @(negedge clk_i);
        en_i = 1'b0;
        repeat (tail) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b expected 0", sck_o); end
        checks++; if (cs_no !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b expected 1", cs_no); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_o); end
    endtask

    task automatic test_positive();
        run_frame(16'h1900, 80, 3);
        checks++; if (fall_q.size() - fb !== 1) begin errors++; $display("FAIL pos_falls: got %0d expected 1", fall_q.size() - fb); end
        checks++;
        if (fall_q.size() > fb) begin
            if (fall_q[fb] - t_en !== 1) begin errors++; $display("FAIL pos_start_latency: got %0d expected 1", fall_q[fb] - t_en); end
        end else begin errors++; $display("FAIL pos_start_latency: got none expected 1"); end
        checks++; if (cs_low_cnt - cb !== 66) begin errors++; $display("FAIL pos_cs_low: got %0d expected 66", cs_low_cnt - cb); end
        checks++; if (sck_rises - rb !== 16) begin errors++; $display("FAIL pos_sck_rises: got %0d expected 16", sck_rises - rb); end
        checks++; if (valid_q.size() - vb !== 1) begin errors++; $display("FAIL pos_valid_cnt: got %0d expected 1", valid_q.size() - vb); end
        checks++;
        if (valid_q.size() > vb && fall_q.size() > fb) begin
            if (valid_q[vb] - fall_q[fb] !== 66) begin errors++; $display("FAIL pos_valid_latency: got %0d expected 66", valid_q[vb] - fall_q[fb]); end
        end else begin errors++; $display("FAIL pos_valid_latency: got none expected 66"); end
        checks++; if (data_o !== 8'h19) begin errors++; $display("FAIL pos_data: got %h expected 19", data_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL pos_err: got %b expected 0", err_o); end
    endtask

    task automatic test_negative();
        run_frame(16'hF000, 80, 3);
        checks++; if (data_o !== 8'hF0) begin errors++; $display("FAIL neg16_data: got %h expected f0", data_o); end
        checks++; if (valid_q.size() - vb !== 1) begin errors++; $display("FAIL neg16_valid_cnt: got %0d expected 1", valid_q.size() - vb); end
        run_frame(16'hFFF0, 80, 3);
        checks++; if (data_o !== 8'hFF) begin errors++; $display("FAIL neg1_data: got %h expected ff", data_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL neg1_err: got %b expected 0", err_o); end
    endtask

    task automatic test_fault();
        run_frame(16'h3C00, 80, 3);
        checks++; if (data_o !== 8'h3C) begin errors++; $display("FAIL fault_pre_data: got %h expected 3c", data_o); end
        run_frame(16'h2E81, 80, 3);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL fault_err: got %b expected 1", err_o); end
        checks++; if (valid_q.size() - vb !== 0) begin errors++; $display("FAIL fault_valid_cnt: got %0d expected 0", valid_q.size() - vb); end
        checks++; if (data_o !== 8'h3C) begin errors++; $display("FAIL fault_data_hold: got %h expected 3c", data_o); end
        checks++; if (sck_rises - rb !== 16) begin errors++; $display("FAIL fault_sck_rises: got %0d expected 16", sck_rises - rb); end
        run_frame(16'h0500, 80, 3);
        checks++; if (data_o !== 8'h05) begin errors++; $display("FAIL fault_post_data: got %h expected 05", data_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL fault_post_err: got %b expected 0", err_o); end
        checks++; if (valid_q.size() - vb !== 1) begin errors++; $display("FAIL fault_post_valid_cnt: got %0d expected 1", valid_q.size() - vb); end
    endtask

    task automatic test_periodicity();
        run_frame(16'h1900, 450, 80);
        checks++; if (fall_q.size() - fb !== 5) begin errors++; $display("FAIL per_falls: got %0d expected 5", fall_q.size() - fb); end
        checks++; if (valid_q.size() - vb !== 5) begin errors++; $display("FAIL per_valid_cnt: got %0d expected 5", valid_q.size() - vb); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (fall_q.size() > fb + i) begin
                if (fall_q[fb+i] - t_en !== 1 + 100 * i) begin
                    errors++; $display("FAIL per_fall%0d: got %0d expected %0d", i, fall_q[fb+i] - t_en, 1 + 100 * i);
                end
            end else begin errors++; $display("FAIL per_fall%0d: got none expected %0d", i, 1 + 100 * i); end
            checks++;
            if (fall_q.size() > fb + i && valid_q.size() > vb + i) begin
                if (valid_q[vb+i] - fall_q[fb+i] !== 66) begin
                    errors++; $display("FAIL per_valid%0d: got %0d expected 66", i, valid_q[vb+i] - fall_q[fb+i]);
                end
            end else begin errors++; $display("FAIL per_valid%0d: got none expected 66", i); end
        end
    endtask

    task automatic test_en_drop();
        int n;
        sensor_word = 16'h2A50;
        mark_bases();
        @(negedge clk_i);
        en_i = 1'b1;
        n = 0;
        while (sck_rises - rb < 5 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        checks++; if (sck_rises - rb < 5) begin errors++; $display("FAIL drop_wait: got %0d rises expected 5", sck_rises - rb); end
        en_i = 1'b0;
        repeat (300) @(negedge clk_i);
        checks++; if (fall_q.size() - fb !== 1) begin errors++; $display("FAIL drop_falls: got %0d expected 1", fall_q.size() - fb); end
        checks++; if (valid_q.size() - vb !== 1) begin errors++; $display("FAIL drop_valid_cnt: got %0d expected 1", valid_q.size() - vb); end
        checks++; if (sck_rises - rb !== 16) begin errors++; $display("FAIL drop_sck_rises: got %0d expected 16", sck_rises - rb); end
        checks++; if (data_o !== 8'h2A) begin errors++; $display("FAIL drop_data: got %h expected 2a", data_o); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        sensor_word = 16'h4B00;
        mark_bases();
        @(negedge clk_i);
        en_i = 1'b1;
        n = 0;
        while (sck_rises - rb < 8 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        checks++; if (sck_rises - rb < 8) begin errors++; $display("FAIL rmid_wait: got %0d rises expected 8", sck_rises - rb); end
        rst_ni = 1'b0;
        #1;
        checks++; if (cs_no !== 1'b1) begin errors++; $display("FAIL rmid_cs: got %b expected 1", cs_no); end
        checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL rmid_sck: got %b expected 0", sck_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b expected 0", err_o); end
        repeat (2) @(negedge clk_i);
        sensor_word = 16'hE700;
        mark_bases();
        rst_ni = 1'b1;
        repeat (80) @(negedge clk_i);
        en_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (fall_q.size() - fb !== 1) begin errors++; $display("FAIL rmid_falls: got %0d expected 1", fall_q.size() - fb); end
        checks++; if (sck_rises - rb !== 16) begin errors++; $display("FAIL rmid_sck_rises: got %0d expected 16", sck_rises - rb); end
        checks++; if (cs_low_cnt - cb !== 66) begin errors++; $display("FAIL rmid_cs_low: got %0d expected 66", cs_low_cnt - cb); end
        checks++; if (valid_q.size() - vb !== 1) begin errors++; $display("FAIL rmid_valid_cnt: got %0d expected 1", valid_q.size() - vb); end
        checks++; if (data_o !== 8'hE7) begin errors++; $display("FAIL rmid_new_data: got %h expected e7", data_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rmid_new_err: got %b expected 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_fault();
        test_periodicity();
        test_en_drop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/temp_sensor_reader.md
# temp_sensor_reader

- Periodic SPI master (mode 0) that reads 16-bit frames from the board temperature sensor.
- Converts each frame to an 8-bit two's-complement integer temperature in °C.
- Presents the result with a one-cycle valid strobe.
- Sits on the producer side of the status path: its `data_o` feeds the 8-bit signed temperature input of the 14-segment status display.

## Interface
- `CLK_DIV`, default 4: SCK half-period in `clk_i` cycles; legal range ≥1.
- `SAMPLE_PERIOD`, default 1000: `clk_i` cycles from one frame start to the next; must be ≥ 33*`CLK_DIV`+2.
- `clk_i`  input  1  system clock.
- `rst_ni`  input  1  asynchronous, active-low reset.
- `en_i`  input  1  enables periodic sampling.
- `miso_i`  input  1  sensor serial data; already synchronised.
- `sck_o`  output  1  SPI clock; idles low.
- `cs_no`  output  1  sensor chip select, active low.
- `data_o`  output  8  last good temperature, signed, 1 °C/LSB.
- `valid_o`  output  1  one-cycle pulse when `data_o` is updated.
- `err_o`  output  1  fault flag from the most recently completed frame.

## Operation
- **Frame format:** 16 bits, MSB first.
  - word[15:4]: 12-bit signed temperature, 0.0625 °C/LSB.
  - word[3:1]: don't care.
  - word[0]: sensor fault flag.
- **Conversion:** `data_o` = word[15:8], i.e. the integer part, truncated toward −∞. No saturation is needed.
- **FSM states:** IDLE, SETUP, SCK_HIGH, SCK_LOW, DONE.
- **IDLE:** `cs_no`=1, `sck_o`=0.
  - Go to SETUP when a start is due:
    - the first cycle `en_i` is sampled high while in IDLE, or
    - the period counter reaches `SAMPLE_PERIOD`−1.
- **SETUP:** `cs_no`=0, `sck_o`=0 for `CLK_DIV` cycles, then go to SCK_HIGH.
- **SCK_HIGH:** `sck_o`=1 for `CLK_DIV` cycles, then go to SCK_LOW.
  - `miso_i` is shifted into the 16-bit shift register on the `clk_i` edge that drives `sck_o` 0→1.
- **SCK_LOW:** `sck_o`=0 for `CLK_DIV` cycles.
  - Bit counter increments on exit.
  - After bit 16, go to DONE; otherwise go back to SCK_HIGH.
- **DONE (one cycle):** `cs_no`=1, then return to IDLE.
  - On the edge entering DONE, the frame result is applied:
    - word[0]=0: `data_o`←word[15:8], `valid_o` pulses for 1 cycle, `err_o`←0.
    - word[0]=1: `data_o` holds, no `valid_o` pulse, `err_o`←1.
- **Period counter:**
  - Resets to 0 on each frame start.
  - Counts every cycle while `en_i`=1.
  - Is held at 0 while `en_i`=0.
- **`en_i` falling mid-frame:** the frame completes and reports normally; no further frame starts.
- **`en_i` held high:** frame starts are exactly `SAMPLE_PERIOD` cycles apart.

## Timing
- **Reset values (async):** `sck_o`=0, `cs_no`=1, `data_o`=8'h00, `valid_o`=0, `err_o`=0. FSM is in IDLE, all counters 0.
- **Reset mid-frame:** immediate abort. `cs_no`=1 and `sck_o`=0 asynchronously; the partial frame is discarded.
- **Start latency:** `cs_no` falls 1 cycle after `en_i` is first sampled high.
- **Chip select:** `cs_no` low for exactly 33*`CLK_DIV` cycles per frame.
- **Clock edges:** the first `sck_o` rise comes `CLK_DIV` cycles after `cs_no` falls. Each frame has exactly 16 rising edges.
- **Result timing:** `valid_o`/`err_o`/`data_o` change on the same edge that raises `cs_no`. `valid_o` is high for exactly 1 cycle.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs.

## Test plan
All scenarios use `CLK_DIV`=2 and `SAMPLE_PERIOD`=100.
- **Positive reading:** sensor word 16'h1900 → `data_o`=8'h19 (25), one `valid_o` pulse, `err_o`=0; `cs_no` low for 66 cycles; 16 `sck_o` rises.
- **Negative readings:**
  - 16'hF000 → `data_o`=8'hF0 (−16).
  - 16'hFFF0 → `data_o`=8'hFF (−1, truncation toward −∞).
- **Fault frame:** after a good 16'h3C00 frame, send 16'h2E81 → `err_o`=1, no `valid_o`, `data_o` stays 8'h3C. The next good frame 16'h0500 gives `data_o`=8'h05 and `err_o`=0.
- **Periodicity:** `en_i` held high for 450 cycles → `cs_no` falling edges at cycles 1, 101, 201, 301, 401 after `en_i` rise; `valid_o` fires 66 cycles after each fall.
- **`en_i` dropped mid-frame:** drop `en_i` at the 5th `sck_o` rise → the frame completes with `valid_o`, and no new `cs_no` fall occurs for 300 cycles.
- **Reset mid-frame:** assert `rst_ni`=0 at the 8th `sck_o` rise → `cs_no`=1, `sck_o`=0, `data_o`=0, `valid_o`=0, `err_o`=0 immediately. After release with `en_i`=1, a fresh full 16-bit frame is read correctly.
